// File: rtl/seg_scan_decoder_if.sv
// Seven-segment scan bus plus the decoded-frame outputs of seg_scan_decoder.
// master: the side driving an/seg and consuming the decoded frame (bench / top level).
// slave:  the decoder itself.
interface seg_scan_decoder_if;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [31:0] value;
    logic        frame_valid;
    logic [15:0] frame_cnt;
    logic        digit_err;
    logic [7:0]  dp;

    modport master (
        output an,
        output seg,
        input  value,
        input  frame_valid,
        input  frame_cnt,
        input  digit_err,
        input  dp
    );

    modport slave (
        input  an,
        input  seg,
        output value,
        output frame_valid,
        output frame_cnt,
        output digit_err,
        output dp
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed 8-digit seven-segment bus (active-low an/seg).
// Debounces each scanned slot, decodes the segment pattern to a hex nibble and
// reassembles complete 8-digit frames into a 32-bit word with a one-cycle strobe.
// Optional feature macro: SEG_DECODE_DP_EN (track decimal points; otherwise seg[7]
// is ignored and dp is tied to 0).
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic             clk,
    input logic             rst,
    seg_scan_decoder_if.slave bus
);

    localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

`ifdef SEG_DECODE_DP_EN
    localparam logic [15:0] IgnoreBits = 16'h0000;
`else
    // Forcing seg[7] high keeps dp out of the stability compare.
    localparam logic [15:0] IgnoreBits = 16'h0080;
`endif

    // Returns {valid, nibble} for a 7-bit active-low segment pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [15:0] smp_q, smp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] value_q, value_d;
    logic        frame_valid_q, frame_valid_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        digit_err_q, digit_err_d;
    logic [7:0]  dp_shadow_q, dp_shadow_d;
    logic [7:0]  dp_q, dp_d;

    logic [15:0] sample;
    logic        changed;
    logic        capture;
    logic [3:0]  zero_cnt;
    logic [2:0]  slot;
    logic [4:0]  dec;

    // Count selected anodes and find the selected slot index.
    always_comb begin
        zero_cnt = 4'd0;
        slot     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.an[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                slot     = 3'(i);
            end
        end
    end

    // Stability window, segment decode and frame assembly.
    always_comb begin
        sample  = {bus.an, bus.seg} | IgnoreBits;
        changed = (sample != smp_q);
        dec     = seg_decode(bus.seg[6:0]);

        smp_d         = sample;
        mask_d        = mask_q;
        shadow_d      = shadow_q;
        value_d       = value_q;
        frame_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        digit_err_d   = 1'b0;
        dp_shadow_d   = dp_shadow_q;
        dp_d          = dp_q;

        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q == StableCnt) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // Fires once per window: either the count just arrived at the limit, or
        // (STABLE_CYCLES == 1) a new pattern restarted an already-saturated counter.
        capture = (cnt_d == StableCnt) && (changed || (cnt_q != StableCnt));

        if (capture && (zero_cnt != 4'd0)) begin
            if ((zero_cnt > 4'd1) || !dec[4]) begin
                digit_err_d = 1'b1;
            end else begin
                shadow_d[{slot, 2'b00} +: 4] = dec[3:0];
                mask_d                       = mask_q | (8'b1 << slot);
                dp_shadow_d[slot]            = ~bus.seg[7];
                if (mask_d == 8'hFF) begin
                    value_d       = shadow_d;
                    dp_d          = dp_shadow_d;
                    frame_valid_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                    mask_d        = 8'h00;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q         <= 16'hFFFF;
            cnt_q         <= 8'd0;
            mask_q        <= 8'h00;
            shadow_q      <= 32'h0;
            value_q       <= 32'h0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= 16'h0;
            digit_err_q   <= 1'b0;
            dp_shadow_q   <= 8'h00;
            dp_q          <= 8'h00;
        end else begin
            smp_q         <= smp_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            digit_err_q   <= digit_err_d;
            dp_shadow_q   <= dp_shadow_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.digit_err   = digit_err_q;
`ifdef SEG_DECODE_DP_EN
    assign bus.dp          = dp_q;
`else
    assign bus.dp          = 8'h00;
`endif

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Verification-side receiver for the multiplexed seven-segment bus (`an`/`seg`) that the single-cycle MIPS top drives to the board display. It watches the scanned anode/segment lines and debounces each digit slot over a stability window. It decodes each segment pattern back to a hex nibble and reassembles the 8-digit value into a 32-bit word with a frame strobe. Benches and on-board self-checks use it to read the CPU's displayed result without parsing raw segment waveforms.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a digit is captured. Legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `an`  in  8  anode selects, active-low. `an[i]=0` selects digit i; digit 7 is the most significant nibble.
- `seg`  in  8  segment lines, active-low. `seg[0..6]` = a..g, `seg[7]` = dp.
- `value`  out  32  last complete frame; nibble i = digit i.
- `frame_valid`  out  1  one-cycle strobe when `value` updates.
- `frame_cnt`  out  16  count of completed frames; wraps 0xFFFF→0x0000.
- `digit_err`  out  1  one-cycle strobe on an invalid capture.
- `dp`  out  8  decimal-point state per digit in the last frame (see Configuration).

## Operation
- Input register: `{an,seg}` is sampled every edge into `smp`.
- Stability counter `cnt`, saturating at `STABLE_CYCLES`:
  - new sample ≠ `smp` → `cnt`=1.
  - new sample = `smp` → `cnt`+1.
- Capture fires on the edge where `cnt` reaches `STABLE_CYCLES`. Exactly one capture occurs per stable window.
- Anode classification at capture:
  - all ones: idle, no action, no error.
  - exactly one zero: valid slot i.
  - more than one zero: `digit_err`.
- Segment decode, `seg[6:0]` to nibble:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E
  - Any other pattern, including blank 0x7F: `digit_err`, slot not written.
- Valid capture:
  - `shadow[i]` ← nibble and `mask[i]` ← 1.
  - A repeat capture of an already-set slot overwrites the nibble; the mask is unchanged.
- Frame completion: when a capture makes `mask`=0xFF, on that same edge:
  - `value` ← shadow with the new nibble merged.
  - `frame_valid` ← 1.
  - `frame_cnt` increments.
  - `mask` ← 0.
- An error capture does not clear `mask`. The partial frame continues.

## Timing
- Reset values: `value`=0, `frame_valid`=0, `frame_cnt`=0, `digit_err`=0, `dp`=0. Internal `smp`=0xFFFF, `cnt`=0, `mask`=0, `shadow`=0.
- Capture latency: a pattern present at the port for edges k..k+STABLE_CYCLES-1 is captured at edge k+STABLE_CYCLES-1. The effects are visible in the following cycle.
- With `STABLE_CYCLES`=1, every edge whose sample differs from the previous sample is a capture.
- `frame_valid` and `digit_err` are registered. Each is high for exactly one cycle.
- `frame_valid` and `digit_err` cannot assert in the same cycle, because there is one capture per edge.
- `rst` high at any edge, including mid-frame, discards the partial frame. All state returns to reset values at that edge.
- A pattern change one cycle before the window completes restarts the window. No capture occurs.

## Configuration
- `SEG_DECODE_DP_EN` defined:
  - `seg[7]` is checked at capture.
  - `dp_shadow[i]` ← `~seg[7]`.
  - `dp` is loaded from `dp_shadow` with `value` on frame completion.
  - `seg[7]` takes part in the stability compare.
- `SEG_DECODE_DP_EN` undefined:
  - `seg[7]` is ignored, including in the stability compare.
  - `dp` is tied to 0.

## Test plan
- Reset, then scan digits 0..7 showing 0x12345678 (digit 7 = "1", pattern 0x79), each held 4 cycles → one `frame_valid`, `value`=0x12345678, `frame_cnt`=1.
- Each slot held only 3 cycles with `STABLE_CYCLES`=4 → no captures, `frame_valid` never asserts, `value` stays 0.
- Digit 3 shows 0x7F (blank) → `digit_err` pulses once. Re-scan with 0x30 on digit 3 → frame completes with nibble 3 = 3.
- `an`=0xFC (two digits selected) held 4 cycles → `digit_err` pulse, `mask` unchanged.
- Six digits captured, `rst` high one cycle, then full scan of 0xDEADBEEF → `frame_cnt`=1, `value`=0xDEADBEEF.
- With `SEG_DECODE_DP_EN` defined, `seg[7]`=0 on digit 0 only → `dp`=0x01 after the frame. Without the macro → `dp`=0x00.
